// File: rtl/chargen_port_arbiter.sv
// chargen_port_arbiter: shares one char-gen RAM port between the video fetcher (priority,
// fixed 3-cycle read latency) and the host font loader (req/ack with auto-increment pointer).
module chargen_port_arbiter #(
    parameter int AW         = 11,
    parameter int DW         = 6,
    parameter int STARVE_MAX = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vid_req,
    input  logic [AW-1:0] i_vid_addr,
    output logic          o_vid_valid,
    output logic [DW-1:0] o_vid_data,
    input  logic          i_host_req,
    input  logic          i_host_we,
    input  logic          i_host_auto,
    input  logic [AW-1:0] i_host_addr,
    input  logic [DW-1:0] i_host_wdata,
    input  logic          i_host_ptr_ld,
    output logic          o_host_ack,
    output logic [DW-1:0] o_host_rdata,
    output logic          o_host_busy,
    output logic [AW-1:0] o_host_ptr,
    output logic          o_starve_flag,
    input  logic          i_starve_clr,
    output logic          o_ram_ce,
    output logic          o_ram_we,
    output logic          o_ram_oce,
    output logic [AW-1:0] o_ram_ad,
    output logic [DW-1:0] o_ram_din,
    input  logic [DW-1:0] i_ram_do
);
    logic          r_inflight, r_flag, r_oce, r_ce, r_we;
    logic [AW-1:0] r_ptr, r_ad;
    logic [DW-1:0] r_din;
    logic [7:0]    r_cnt;
    logic [2:0]    r_tv, r_th;
    logic          w_host_issue, w_blocked, w_ack, w_set, w_ld, w_vid;
    logic [AW-1:0] w_host_ad;
    logic [7:0]    w_cnt_nxt;

    always_comb begin
        w_host_issue = !i_vid_req && i_host_req && !r_inflight;
        w_blocked    = i_vid_req && i_host_req && !r_inflight;
        w_host_ad    = i_host_auto ? r_ptr : i_host_addr;
        w_ld         = i_host_ptr_ld && !r_inflight;
        w_ack        = r_tv[2] && r_th[2];
        w_vid        = r_tv[2] && !r_th[2];
        w_cnt_nxt    = w_host_issue ? 8'd0 :
                       (w_blocked && r_cnt < 8'(STARVE_MAX)) ? r_cnt + 8'd1 : r_cnt;
        w_set        = w_blocked && w_cnt_nxt >= 8'(STARVE_MAX);
    end

    // Tag pipeline {owner, valid} lines up with the RAM's two-register read path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_flag     <= 1'b0;
            r_oce      <= 1'b0;
            r_ce       <= 1'b0;
            r_we       <= 1'b0;
            r_ptr      <= '0;
            r_ad       <= '0;
            r_din      <= '0;
            r_cnt      <= '0;
            r_tv       <= '0;
            r_th       <= '0;
        end else begin
            r_oce      <= 1'b1;
            r_ce       <= i_vid_req || w_host_issue;
            r_we       <= w_host_issue && i_host_we;
            r_ad       <= i_vid_req ? i_vid_addr : w_host_issue ? w_host_ad : r_ad;
            r_din      <= w_host_issue ? i_host_wdata : r_din;
            r_tv       <= {r_tv[1:0], i_vid_req || w_host_issue};
            r_th       <= {r_th[1:0], w_host_issue};
            r_inflight <= w_host_issue ? 1'b1 : w_ack ? 1'b0 : r_inflight;
            r_ptr      <= w_ld ? i_host_addr : (w_host_issue && i_host_auto) ? r_ptr + AW'(1) : r_ptr;
            r_cnt      <= w_cnt_nxt;
            r_flag     <= w_set ? 1'b1 : i_starve_clr ? 1'b0 : r_flag;
        end
    end

    always_comb begin
        o_vid_valid   = w_vid;
        o_vid_data    = w_vid ? i_ram_do : '0;
        o_host_ack    = w_ack;
        o_host_rdata  = w_ack ? i_ram_do : '0;
        o_host_busy   = r_inflight;
        o_host_ptr    = r_ptr;
        o_starve_flag = r_flag;
        o_ram_ce      = r_ce;
        o_ram_we      = r_we;
        o_ram_oce     = r_oce;
        o_ram_ad      = r_ad;
        o_ram_din     = r_din;
    end
endmodule

// File: tb/tb_chargen_port_arbiter.sv
// tb_chargen_port_arbiter: randomized + directed stimulus, transaction-level reference model
// feeding scoreboard queues that a negedge monitor drains against the DUT.
module tb_chargen_port_arbiter;
    localparam int AW = 11, DW = 6, SMAX = 15;
    typedef struct { int c; int a; int d; int w; } ev_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic vid_req = 0, host_req = 0, host_we = 0, host_auto = 0, host_ptr_ld = 0, starve_clr = 0;
    logic [AW-1:0] vid_addr = '0, host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic vid_valid, host_ack, host_busy, starve_flag, ram_ce, ram_we, ram_oce;
    logic [DW-1:0] vid_data, host_rdata, ram_din, ram_do, r_q;
    logic [AW-1:0] host_ptr, ram_ad;
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] shadow [2**AW];

    ev_t vq[$], hq[$], iq[$];
    int cyc = 0, n_chk = 0, n_err = 0;
    int m_free = 0, m_issue = -10, m_drop = -1, m_cnt = 0, m_ptr = 0;
    bit m_flag = 0, run = 0;

    chargen_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_vid_req(vid_req), .i_vid_addr(vid_addr), .o_vid_valid(vid_valid), .o_vid_data(vid_data),
        .i_host_req(host_req), .i_host_we(host_we), .i_host_auto(host_auto), .i_host_addr(host_addr),
        .i_host_wdata(host_wdata), .i_host_ptr_ld(host_ptr_ld), .o_host_ack(host_ack),
        .o_host_rdata(host_rdata), .o_host_busy(host_busy), .o_host_ptr(host_ptr),
        .o_starve_flag(starve_flag), .i_starve_clr(starve_clr),
        .o_ram_ce(ram_ce), .o_ram_we(ram_we), .o_ram_oce(ram_oce), .o_ram_ad(ram_ad),
        .o_ram_din(ram_din), .i_ram_do(ram_do)
    );

    always #5 clk = ~clk;

    // RAM with output register: address in n+1, data on ram_do in n+3
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_ad] <= ram_din;
            else r_q <= mem[ram_ad];
        end
        if (ram_oce) ram_do <= r_q;
    end

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic bad(string name);
        n_chk++;
        n_err++;
        $display("FAIL %s cycle %0d", name, cyc);
    endtask

    // Reference model: evaluates the cycle that is ending, using the spec's arbitration rules.
    task automatic model();
        bit b, hiss, blk;
        int a;
        b    = cyc > m_issue && cyc < m_free;
        hiss = !vid_req && host_req && !b;
        blk  = vid_req && host_req && !b;
        if (vid_req) begin
            vq.push_back('{cyc + 3, int'(vid_addr), int'(shadow[vid_addr]), 0});
            iq.push_back('{cyc + 1, int'(vid_addr), 0, 0});
        end else if (hiss) begin
            a = host_auto ? m_ptr : int'(host_addr);
            if (host_we) shadow[a] = host_wdata;
            hq.push_back('{cyc + 3, a, int'(shadow[a]), int'(host_we)});
            iq.push_back('{cyc + 1, a, int'(host_wdata), int'(host_we)});
            m_issue = cyc;
            m_free  = cyc + 4;
            m_drop  = cyc + 4;
        end
        if (host_ptr_ld && !b) m_ptr = int'(host_addr);
        else if (hiss && host_auto) m_ptr = (m_ptr + 1) % (2**AW);
        if (hiss) m_cnt = 0;
        else if (blk && m_cnt < SMAX) m_cnt++;
        if (blk && m_cnt >= SMAX) m_flag = 1;
        else if (starve_clr) m_flag = 0;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model();
        cyc++;
        #1;
        if (cyc == m_drop) host_req = 0;
        vid_req = 0;
        host_ptr_ld = 0;
        starve_clr = 0;
    endtask

    task automatic host_start(bit we, bit au, int a, int d);
        host_req = 1;
        host_we = we;
        host_auto = au;
        host_addr = AW'(a);
        host_wdata = DW'(d);
    endtask

    task automatic host_wait();
        for (int i = 0; i < 100 && host_req; i++) step();
        if (host_req) begin
            bad("host_wait_timeout");
            host_req = 0;
        end
    endtask

    task automatic chk_zero(string t);
        chk({t, "_vid_valid"}, vid_valid, 0);
        chk({t, "_vid_data"}, vid_data, 0);
        chk({t, "_host_ack"}, host_ack, 0);
        chk({t, "_host_rdata"}, host_rdata, 0);
        chk({t, "_host_busy"}, host_busy, 0);
        chk({t, "_host_ptr"}, host_ptr, 0);
        chk({t, "_starve_flag"}, starve_flag, 0);
        chk({t, "_ram_ce"}, ram_ce, 0);
        chk({t, "_ram_we"}, ram_we, 0);
        chk({t, "_ram_oce"}, ram_oce, 0);
        chk({t, "_ram_ad"}, ram_ad, 0);
        chk({t, "_ram_din"}, ram_din, 0);
    endtask

    always @(negedge clk) if (run && rst_n) begin
        ev_t e;
        while (vq.size() > 0 && vq[0].c < cyc) begin e = vq.pop_front(); bad("vid_missing"); end
        while (hq.size() > 0 && hq[0].c < cyc) begin e = hq.pop_front(); bad("host_ack_missing"); end
        while (iq.size() > 0 && iq[0].c < cyc) begin e = iq.pop_front(); bad("ram_issue_missing"); end
        if (vid_valid) begin
            if (vq.size() == 0) bad("vid_spurious");
            else begin
                e = vq.pop_front();
                chk("vid_cycle", cyc, e.c);
                chk("vid_data", vid_data, e.d);
            end
        end
        if (host_ack) begin
            if (hq.size() == 0) bad("host_ack_spurious");
            else begin
                e = hq.pop_front();
                chk("host_ack_cycle", cyc, e.c);
                if (e.w == 0) chk("host_rdata", host_rdata, e.d);
            end
        end
        if (ram_ce) begin
            if (iq.size() == 0) bad("ram_ce_spurious");
            else begin
                e = iq.pop_front();
                chk("ram_cycle", cyc, e.c);
                chk("ram_ad", ram_ad, e.a);
                chk("ram_we", ram_we, e.w);
                if (e.w != 0) chk("ram_din", ram_din, e.d);
            end
        end
        chk("host_busy", host_busy, int'(cyc > m_issue && cyc < m_free));
        chk("host_ptr", host_ptr, m_ptr);
        chk("starve_flag", starve_flag, int'(m_flag));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            mem[i] = DW'(i * 7 + 14);
            shadow[i] = DW'(i * 7 + 14);
        end
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1;
        run = 1;
        step();
        chk("oce_after_reset", ram_oce, 1);

        vid_req = 1; vid_addr = '0;
        step();
        chk("vid0_ram_ce", ram_ce, 1);
        chk("vid0_ram_ad", ram_ad, 0);
        step(); step();
        chk("vid0_valid", vid_valid, 1);
        chk("vid0_data", vid_data, 'h0E);

        host_start(1, 0, 'h400, 'h3F);
        step();
        chk("hw_busy", host_busy, 1);
        host_wait();
        vid_req = 1; vid_addr = 'h400;
        step(); step(); step();
        chk("readback_valid", vid_valid, 1);
        chk("readback_data", vid_data, 'h3F);

        host_start(0, 0, 'h020, 0);
        for (int i = 0; i < 5; i++) begin
            vid_req = 1; vid_addr = AW'($urandom);
            step();
        end
        chk("conflict_busy_pre", host_busy, 0);
        host_wait();

        host_addr = 'h7FE; host_ptr_ld = 1;
        step();
        chk("ptr_load", host_ptr, 'h7FE);
        for (int i = 0; i < 3; i++) begin
            host_start(1, 1, 0, i + 1);
            host_wait();
        end
        chk("ptr_wrap", host_ptr, 'h001);

        host_start(0, 0, 'h010, 0);
        for (int i = 0; i < 20; i++) begin
            vid_req = 1; vid_addr = AW'($urandom);
            step();
        end
        chk("starve_set", starve_flag, 1);
        host_wait();
        chk("starve_sticky", starve_flag, 1);
        starve_clr = 1;
        step();
        chk("starve_clr", starve_flag, 0);

        for (int i = 0; i < 400; i++) begin
            vid_req = ($urandom_range(0, 3) != 0); vid_addr = AW'($urandom);
            if (!host_req) begin
                if ($urandom_range(0, 9) == 0) begin host_addr = AW'($urandom); host_ptr_ld = 1; end
                if ($urandom_range(0, 2) == 0)
                    host_start(1'($urandom), 1'($urandom), int'($urandom_range(0, 2047)), int'($urandom_range(0, 63)));
            end
            if ($urandom_range(0, 19) == 0) starve_clr = 1;
            step();
        end
        host_wait();
        repeat (5) step();

        host_start(0, 0, 'h155, 0);
        step(); step();
        rst_n = 0;
        #1;
        chk_zero("midop");
        host_req = 0;
        vq.delete(); hq.delete(); iq.delete();
        m_free = 0; m_issue = -10; m_drop = -1; m_cnt = 0; m_ptr = 0; m_flag = 0;
        repeat (2) step();
        rst_n = 1;
        repeat (4) step();
        host_start(0, 0, 'h155, 0);
        host_wait();
        vid_req = 1; vid_addr = 'h3;
        step();
        repeat (6) step();

        chk("vq_empty", vq.size(), 0);
        chk("hq_empty", hq.size(), 0);
        chk("iq_empty", iq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/chargen_port_arbiter.md
# chargen_port_arbiter

Single-port arbiter and sequencer for one port of the 2048×6 character-generator RAM. It shares that port between the video scan fetcher and the host font loader (ESP32 bridge). The video fetcher always has priority and sees a fixed read latency. The host gets a req/ack handshake with an optional auto-incrementing address pointer for streaming font loads. It also tracks the RAM's pipelined output register and flags host starvation.

## Interface
Parameters:
- AW, 11, RAM address width (2048 entries).
- DW, 6, RAM data width.
- STARVE_MAX, 15, consecutive blocked host cycles before starve_flag sets (max 255).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- vid_req  in  1  video read request, one cycle per fetch.
- vid_addr  in  AW  video read address.
- vid_valid  out  1  vid_data valid this cycle.
- vid_data  out  DW  video read data (= ram_do).
- host_req  in  1  host access request, level, held until host_ack.
- host_we  in  1  1 = write, 0 = read; held with host_req.
- host_auto  in  1  1 = use internal pointer as address.
- host_addr  in  AW  explicit address / pointer load value.
- host_wdata  in  DW  write data.
- host_ptr_ld  in  1  load pointer from host_addr.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DW  read data, valid with host_ack.
- host_busy  out  1  host op accepted and not yet acked.
- host_ptr  out  AW  current pointer.
- starve_flag  out  1  sticky starvation indicator.
- starve_clr  in  1  clears starve_flag.
- ram_ce, ram_we  out  1  RAM port enable / write enable, registered.
- ram_oce  out  1  output-register enable; 0 in reset, 1 otherwise.
- ram_ad  out  AW  registered RAM address.
- ram_din  out  DW  registered RAM write data.
- ram_do  in  DW  RAM output, pipelined (output register enabled).

## Operation
- Issue decision in cycle n, from inputs sampled at the edge ending n:
  - vid_req=1 → video issue (read).
  - else host_req=1 and host_inflight=0 → host issue; host_inflight set.
  - else idle: ram_ce=0, ram_we=0 in n+1.
- Issue registers ram_ce=1, ram_we (host_we for host, 0 for video), ram_ad and ram_din, all valid in cycle n+1.
- Host address is host_ptr when host_auto=1, else host_addr.
- Host issue with host_auto=1 increments host_ptr by 1 modulo 2^AW (0x7FF → 0x000).
- host_ptr_ld is honoured only when host_busy=0; if it coincides with a host issue, the load wins and no increment occurs.
- A 3-stage tag pipeline carries {owner, valid} per issue.
  - Stage 3 is active in cycle n+3; there ram_do holds read data.
  - Video tag: vid_valid=1. Host tag: host_ack=1 and host_rdata=ram_do.
  - Host writes also ack at n+3; host_rdata is don't-care for writes.
- host_inflight/host_busy clear at the edge ending the ack cycle. Earliest next host issue is cycle n+4, so one host op is outstanding at a time.
- Starvation counter:
  - Increments each cycle with host_req=1, host_inflight=0, vid_req=1.
  - Resets to 0 on any host issue.
  - Reaching STARVE_MAX sets starve_flag; counter saturates.
  - starve_clr clears the flag. If a set condition occurs in the same cycle, set wins.
- Host may not drop host_req before ack; behaviour is undefined if it does.

## Timing
- Reset values: every output 0, including ram_oce, host_ptr, starve_flag and the tag pipeline.
- Reset mid-operation discards in-flight tags: no ack or valid is produced for ops issued before reset.
- Video latency is fixed: vid_req in cycle n → vid_valid in n+3, unaffected by host traffic.
- Back-to-back video requests are accepted every cycle.
- Host latency is 3 cycles plus blocked cycles.
- Simultaneous vid_req and host_req: video issues, host waits, and the starve counter counts.

## Test plan
- Video read: after reset, vid_req with vid_addr=0x000 → ram_ad=0x000 and ram_ce=1 in n+1, then vid_valid=1 in n+3 with vid_data=0x0E (first row of '@').
- Host write/readback: host write 0x3F to 0x400, ack in n+3 with host_busy high n+1..n+3. Then vid_req to 0x400 → vid_data=0x3F.
- Conflict: vid_req high for 5 cycles while host_req is pending → five vid_valid pulses at fixed +3 latency. Host issues in the first free cycle; host_ack follows 3 cycles later.
- Auto-increment wrap: host_ptr_ld with host_addr=0x7FE, then three auto writes → ram_ad 0x7FE, 0x7FF, 0x000 and final host_ptr=0x001.
- Starvation: vid_req held high for 20 cycles with host_req pending → starve_flag set after 15 blocked cycles and remains set after vid_req drops. starve_clr clears it.
- Reset mid-op: assert rst_n low in cycle n+2 of a host read → no host_ack, all outputs 0 and host_ptr=0 immediately. First request after release behaves normally.
